// File: rtl/template_pkg.sv
// template_pkg: shared constants and types for the startup/heartbeat timer
package template_pkg;
    localparam int TEMPLATE_DEFAULT_PERIOD = 8;
    localparam int TEMPLATE_TICK_CNT_W     = 16;
    typedef logic [TEMPLATE_TICK_CNT_W-1:0] tick_cnt_t;
    function automatic bit period_is_legal(input int period);
        return period >= 2 && period <= 65535;
    endfunction
endpackage

// File: rtl/template_if.sv
// template_if: status bundle published by the startup/heartbeat timer
interface template_if
    import template_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) ();
    logic                 rst_sync_n;
    logic                 ready;
    logic                 tick;
    logic [CNT_WIDTH-1:0] cycles;
    tick_cnt_t            tick_count;
    modport master (output rst_sync_n, ready, tick, cycles, tick_count);
    modport slave  (input  rst_sync_n, ready, tick, cycles, tick_count);
endinterface

// File: rtl/template_reset_sync.sv
// reset_sync: two-flop reset synchronizer, asynchronous assert, synchronous release
module reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);
    logic r_meta;
    logic r_sync;
    // shift a constant 1 through two flops; rst_n clears both at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end
    assign rst_sync_n = r_sync;
endmodule

// File: rtl/template_core.sv
// template_core: synchronized reset, free-running cycle counter, sticky ready and periodic tick
module template_core
    import template_pkg::*;
#(
    parameter int PARAM     = TEMPLATE_DEFAULT_PERIOD,
    parameter int CNT_WIDTH = 64
) (
    input logic       clk,
    input logic       rst_n,
    template_if.master bus
);
    localparam int PW = $clog2(PARAM);

    if (!period_is_legal(PARAM)) begin : g_bad_param
        $error("template_core: PARAM must be in 2..65535");
    end
    if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_width
        $error("template_core: CNT_WIDTH must be in 8..64");
    end

    logic                 w_rst_sync_n;
    logic                 w_wrap;
    logic [PW-1:0]        r_phase;
    logic [CNT_WIDTH-1:0] r_cycles;
    logic                 r_tick;
    logic                 r_ready;
    tick_cnt_t            r_tick_count;

    reset_sync u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (w_rst_sync_n)
    );

    assign w_wrap = (r_phase == PW'(PARAM - 1));

    // counters advance only once the synchronized reset has released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= '0;
            r_cycles     <= '0;
            r_tick       <= 1'b0;
            r_ready      <= 1'b0;
            r_tick_count <= '0;
        end else if (w_rst_sync_n) begin
            r_cycles     <= r_cycles + CNT_WIDTH'(1);
            r_phase      <= w_wrap ? '0 : r_phase + PW'(1);
            r_tick       <= w_wrap;
            r_ready      <= r_ready | w_wrap;
            r_tick_count <= w_wrap ? r_tick_count + tick_cnt_t'(1) : r_tick_count;
        end else begin
            r_tick       <= 1'b0;
        end
    end

    assign bus.rst_sync_n = w_rst_sync_n;
    assign bus.ready      = r_ready;
    assign bus.tick       = r_tick;
    assign bus.cycles     = r_cycles;
    assign bus.tick_count = r_tick_count;
endmodule

// File: tb/tb_template_core.sv
// tb_template_core: directed checks of the startup/heartbeat timer at three parameter sets
`timescale 1ns/1ps
module tb_template_core;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    template_if #(.CNT_WIDTH(64)) if_main ();
    template_if #(.CNT_WIDTH(8))  if_w8 ();
    template_if #(.CNT_WIDTH(64)) if_p2 ();

    template_core #(.PARAM(8), .CNT_WIDTH(64)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
    template_core #(.PARAM(8), .CNT_WIDTH(8))  u_w8   (.clk(clk), .rst_n(rst_n), .bus(if_w8));
    template_core #(.PARAM(2), .CNT_WIDTH(64)) u_p2   (.clk(clk), .rst_n(rst_n), .bus(if_p2));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rsn"},   64'(if_main.rst_sync_n), 64'd0);
        check({tag, "_ready"}, 64'(if_main.ready),      64'd0);
        check({tag, "_tick"},  64'(if_main.tick),       64'd0);
        check({tag, "_cyc"},   if_main.cycles,          64'd0);
        check({tag, "_tcnt"},  64'(if_main.tick_count), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("sync_after_1st_edge", 64'(if_main.rst_sync_n), 64'd0);
        check("cyc_after_1st_edge",  if_main.cycles,          64'd0);
        @(negedge clk);
        check("sync_after_2nd_edge", 64'(if_main.rst_sync_n), 64'd1);
        check("cyc_after_2nd_edge",  if_main.cycles,          64'd0);
    endtask

    task automatic run(input int last, input bit all_duts);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            check("main_cyc",   if_main.cycles,          64'(n));
            check("main_tick",  64'(if_main.tick),       64'(n % 8 == 0));
            check("main_tcnt",  64'(if_main.tick_count), 64'((n / 8) % 65536));
            check("main_ready", 64'(if_main.ready),      64'(n >= 8));
            if (all_duts) begin
                check("w8_cyc",   64'(if_w8.cycles),     64'(n % 256));
                check("w8_tick",  64'(if_w8.tick),       64'(n % 8 == 0));
                check("w8_ready", 64'(if_w8.ready),      64'(n >= 8));
                check("p2_tick",  64'(if_p2.tick),       64'(n % 2 == 0));
                check("p2_tcnt",  64'(if_p2.tick_count), 64'(n / 2));
                check("p2_ready", 64'(if_p2.ready),      64'(n >= 2));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("hold_reset");
        end
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("sync_after_1st_edge", 64'(if_main.rst_sync_n), 64'd0);
        @(negedge clk);
        check("sync_after_2nd_edge", 64'(if_main.rst_sync_n), 64'd1);
        check("cyc_after_2nd_edge",  if_main.cycles,          64'd0);
        check("w8_cyc_start",        64'(if_w8.cycles),       64'd0);
        run(260, 1'b1);
        #10 rst_n = 1'b0;
        #1 check_zero("reset_after_wrap");
        check("w8_ready_cleared", 64'(if_w8.ready), 64'd0);
        release_reset();
        run(13, 1'b0);
        #10 rst_n = 1'b0;
        #1 check_zero("reset_at_13");
        release_reset();
        run(9, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
